// File: rtl/asg_seq.sv
// Burst-profile sequencer for one asg channel: steps through a small profile
// table, loading each entry into the channel and waiting for its stop interrupt.
module asg_seq #(
  parameter  int PN  = 4,
  parameter  int CWM = 14,
  parameter  int CWL = 32,
  parameter  int CWN = 16,
  parameter  int CWS = 16,
  localparam int PW  = $clog2(PN)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tbl_wen,
  input  logic [PW-1:0]  tbl_adr,
  input  logic [CWM-1:0] tbl_bdl,
  input  logic [CWL-1:0] tbl_bln,
  input  logic [CWN-1:0] tbl_bnm,
  input  logic           ctl_str,
  input  logic           ctl_stp,
  input  logic [PW-1:0]  cfg_num,
  input  logic           cfg_inf,
  input  logic [CWS-1:0] cfg_rep,
  output logic           asg_rst,
  output logic           asg_trg,
  output logic [CWM-1:0] asg_bdl,
  output logic [CWL-1:0] asg_bln,
  output logic [CWN-1:0] asg_bnm,
  input  logic           asg_stp,
  output logic           sts_run,
  output logic [PW-1:0]  sts_idx,
  output logic [CWS-1:0] sts_rep,
  output logic           irq_don,
  output logic           irq_abt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] TRIG  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] NEXT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ABORT = 3'd6;

  localparam logic [PW-1:0] IDX_MAX = PW'(PN - 1);

  logic [CWM-1:0] mem_bdl [PN];
  logic [CWL-1:0] mem_bln [PN];
  logic [CWN-1:0] mem_bnm [PN];

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [PW-1:0]  idx_nxt;
  logic [CWS-1:0] rep_nxt;

  always_comb begin
    state_nxt = state;
    idx_nxt   = sts_idx;
    rep_nxt   = sts_rep;
    case (state)
      IDLE: begin
        if (ctl_str && !ctl_stp) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
          rep_nxt   = '0;
        end
      end
      LOAD: state_nxt = TRIG;
      TRIG: state_nxt = WAIT;
      WAIT: if (asg_stp) state_nxt = NEXT;
      NEXT: begin
        if (sts_idx != cfg_num && sts_idx != IDX_MAX) begin
          idx_nxt   = sts_idx + PW'(1);
          state_nxt = LOAD;
        end else if (cfg_inf || sts_rep != cfg_rep) begin
          idx_nxt   = '0;
          rep_nxt   = sts_rep + CWS'(1);
          state_nxt = LOAD;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every other transition, including a same-cycle asg_stp.
    if (ctl_stp && state != IDLE && state != ABORT) begin
      state_nxt = ABORT;
      idx_nxt   = sts_idx;
      rep_nxt   = sts_rep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sts_idx <= '0;
      sts_rep <= '0;
      sts_run <= 1'b0;
      asg_rst <= 1'b0;
      asg_trg <= 1'b0;
      irq_don <= 1'b0;
      irq_abt <= 1'b0;
      asg_bdl <= '0;
      asg_bln <= '0;
      asg_bnm <= '0;
      for (int i = 0; i < PN; i++) begin
        mem_bdl[i] <= '0;
        mem_bln[i] <= '0;
        mem_bnm[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      sts_idx <= idx_nxt;
      sts_rep <= rep_nxt;
      sts_run <= (state_nxt != IDLE);
      asg_rst <= (state_nxt == LOAD) || (state_nxt == ABORT);
      asg_trg <= (state_nxt == TRIG);
      irq_don <= (state_nxt == DONE);
      irq_abt <= (state_nxt == ABORT);
      // Config is captured from the table before any same-cycle write lands.
      if (state_nxt == LOAD) begin
        asg_bdl <= mem_bdl[idx_nxt];
        asg_bln <= mem_bln[idx_nxt];
        asg_bnm <= mem_bnm[idx_nxt];
      end
      if (tbl_wen) begin
        mem_bdl[tbl_adr] <= tbl_bdl;
        mem_bln[tbl_adr] <= tbl_bln;
        mem_bnm[tbl_adr] <= tbl_bnm;
      end
    end
  end

endmodule

// File: tb/tb_asg_seq.sv
// Directed bench for asg_seq: profile sequencing, repeat/infinite modes,
// abort, ignored events, live table writes and mid-sequence reset.
module tb_asg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tbl_wen = 1'b0;
  logic [1:0]  tbl_adr = '0;
  logic [13:0] tbl_bdl = '0;
  logic [31:0] tbl_bln = '0;
  logic [15:0] tbl_bnm = '0;
  logic        ctl_str = 1'b0;
  logic        ctl_stp = 1'b0;
  logic [1:0]  cfg_num = '0;
  logic        cfg_inf = 1'b0;
  logic [15:0] cfg_rep = '0;
  logic        asg_rst, asg_trg;
  logic [13:0] asg_bdl;
  logic [31:0] asg_bln;
  logic [15:0] asg_bnm;
  logic        asg_stp = 1'b0;
  logic        sts_run;
  logic [1:0]  sts_idx;
  logic [15:0] sts_rep;
  logic        irq_don, irq_abt;

  logic [13:0] m_bdl [4];
  logic [31:0] m_bln [4];
  logic [15:0] m_bnm [4];

  int vectors = 0;
  int errs    = 0;
  int don_cnt = 0;
  int abt_cnt = 0;
  int trg_cnt = 0;

  asg_seq dut (
    .clk(clk), .rst(rst),
    .tbl_wen(tbl_wen), .tbl_adr(tbl_adr), .tbl_bdl(tbl_bdl), .tbl_bln(tbl_bln), .tbl_bnm(tbl_bnm),
    .ctl_str(ctl_str), .ctl_stp(ctl_stp),
    .cfg_num(cfg_num), .cfg_inf(cfg_inf), .cfg_rep(cfg_rep),
    .asg_rst(asg_rst), .asg_trg(asg_trg),
    .asg_bdl(asg_bdl), .asg_bln(asg_bln), .asg_bnm(asg_bnm),
    .asg_stp(asg_stp),
    .sts_run(sts_run), .sts_idx(sts_idx), .sts_rep(sts_rep),
    .irq_don(irq_don), .irq_abt(irq_abt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irq_don) don_cnt++;
    if (irq_abt) abt_cnt++;
    if (asg_trg) trg_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input int a, input logic [13:0] b, input logic [31:0] l, input logic [15:0] n);
    tbl_wen = 1'b1; tbl_adr = a[1:0]; tbl_bdl = b; tbl_bln = l; tbl_bnm = n;
    m_bdl[a] = b; m_bln[a] = l; m_bnm[a] = n;
    tick;
    tbl_wen = 1'b0;
  endtask

  task automatic start;
    ctl_str = 1'b1;
    tick;
    ctl_str = 1'b0;
  endtask

  // Entered with the LOAD cycle visible; returns with the post-NEXT state visible.
  task automatic burst(input int e, input int r, input bit ign, input bit live);
    logic [61:0] cfg_old;
    cfg_old = {m_bdl[e], m_bln[e], m_bnm[e]};
    vectors++;
    if (asg_rst !== 1'b1 || asg_trg !== 1'b0 || irq_don !== 1'b0) begin
      errs++; $display("FAIL load_pulse e=%0d: rst/trg/don=%b%b%b required 100", e, asg_rst, asg_trg, irq_don);
    end
    vectors++;
    if ({asg_bdl, asg_bln, asg_bnm} !== cfg_old) begin
      errs++; $display("FAIL load_cfg e=%0d: got %h required %h", e, {asg_bdl, asg_bln, asg_bnm}, cfg_old);
    end
    vectors++;
    if (sts_idx !== e[1:0] || sts_rep !== 16'(r)) begin
      errs++; $display("FAIL load_sts: idx/rep=%0d/%0d required %0d/%0d", sts_idx, sts_rep, e, r);
    end
    if (ign) asg_stp = 1'b1;
    tick;
    vectors++;
    if (asg_trg !== 1'b1 || asg_rst !== 1'b0 || sts_run !== 1'b1) begin
      errs++; $display("FAIL trig_pulse e=%0d: trg/rst/run=%b%b%b required 101", e, asg_trg, asg_rst, sts_run);
    end
    tick;
    asg_stp = 1'b0;
    for (int c = 2; c < 10; c++) begin
      if (ign && c == 3) ctl_str = 1'b1;
      if (live && c == 4) begin
        tbl_wen = 1'b1; tbl_adr = 2'd0; tbl_bdl = 14'h3abc; tbl_bln = 32'h1234_5678; tbl_bnm = 16'hbeef;
        m_bdl[0] = 14'h3abc; m_bln[0] = 32'h1234_5678; m_bnm[0] = 16'hbeef;
      end
      tick;
      ctl_str = 1'b0;
      tbl_wen = 1'b0;
    end
    vectors++;
    if (asg_rst !== 1'b0 || asg_trg !== 1'b0 || sts_idx !== e[1:0] || sts_run !== 1'b1) begin
      errs++; $display("FAIL wait_hold e=%0d: rst/trg/run=%b%b%b idx=%0d required 001 idx=%0d", e, asg_rst, asg_trg, sts_run, sts_idx, e);
    end
    vectors++;
    if ({asg_bdl, asg_bln, asg_bnm} !== cfg_old) begin
      errs++; $display("FAIL wait_cfg e=%0d: got %h required %h", e, {asg_bdl, asg_bln, asg_bnm}, cfg_old);
    end
    asg_stp = 1'b1;
    tick;
    asg_stp = 1'b0;
    vectors++;
    if (asg_rst !== 1'b0 || asg_trg !== 1'b0 || irq_don !== 1'b0) begin
      errs++; $display("FAIL next_quiet e=%0d: rst/trg/don=%b%b%b required 000", e, asg_rst, asg_trg, irq_don);
    end
    tick;
  endtask

  task automatic test_reset;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin m_bdl[i] = '0; m_bln[i] = '0; m_bnm[i] = '0; end
    vectors++;
    if ({asg_rst, asg_trg, irq_don, irq_abt, sts_run} !== 5'b0 || sts_idx !== 2'd0 || sts_rep !== 16'd0 ||
        {asg_bdl, asg_bln, asg_bnm} !== 62'd0) begin
      errs++; $display("FAIL reset_state: ctl=%b idx=%0d rep=%0d cfg=%h required all zero",
                       {asg_rst, asg_trg, irq_don, irq_abt, sts_run}, sts_idx, sts_rep, {asg_bdl, asg_bln, asg_bnm});
    end
  endtask

  task automatic test_idle_events;
    ctl_str = 1'b1; ctl_stp = 1'b1;
    tick;
    ctl_str = 1'b0; ctl_stp = 1'b0;
    vectors++;
    if (sts_run !== 1'b0 || asg_rst !== 1'b0 || irq_abt !== 1'b0) begin
      errs++; $display("FAIL idle_str_stp: run/rst/abt=%b%b%b required 000", sts_run, asg_rst, irq_abt);
    end
    ctl_stp = 1'b1;
    tick;
    ctl_stp = 1'b0;
    tick;
    vectors++;
    if (sts_run !== 1'b0 || irq_abt !== 1'b0 || asg_rst !== 1'b0) begin
      errs++; $display("FAIL idle_stp: run/abt/rst=%b%b%b required 000", sts_run, irq_abt, asg_rst);
    end
  endtask

  task automatic test_basic;
    int d0;
    for (int i = 0; i < 4; i++) tbl_write(i, 14'(16'h0a0 + i), 32'hdead_0000 + i, 16'h0b00 + 16'(i));
    cfg_num = 2'd2; cfg_rep = 16'd0; cfg_inf = 1'b0;
    d0 = don_cnt;
    start;
    for (int e = 0; e < 3; e++) burst(e, 0, 1'b0, 1'b0);
    vectors++;
    if (irq_don !== 1'b1 || sts_idx !== 2'd2 || sts_rep !== 16'd0) begin
      errs++; $display("FAIL basic_done: don=%b idx=%0d rep=%0d required 1 2 0", irq_don, sts_idx, sts_rep);
    end
    tick;
    vectors++;
    if (irq_don !== 1'b0 || sts_run !== 1'b0 || don_cnt - d0 != 1 || sts_idx !== 2'd2) begin
      errs++; $display("FAIL basic_idle: don=%b run=%b pulses=%0d idx=%0d required 0 0 1 2", irq_don, sts_run, don_cnt - d0, sts_idx);
    end
  endtask

  task automatic test_repeat;
    int t0;
    cfg_num = 2'd2; cfg_rep = 16'd1;
    t0 = trg_cnt;
    start;
    for (int p = 0; p < 2; p++)
      for (int e = 0; e < 3; e++) burst(e, p, (p == 0 && e == 1), 1'b0);
    vectors++;
    if (irq_don !== 1'b1 || sts_rep !== 16'd1 || sts_idx !== 2'd2) begin
      errs++; $display("FAIL repeat_done: don=%b rep=%0d idx=%0d required 1 1 2", irq_don, sts_rep, sts_idx);
    end
    tick;
    vectors++;
    if (trg_cnt - t0 != 6 || sts_run !== 1'b0) begin
      errs++; $display("FAIL repeat_trg: triggers=%0d run=%b required 6 0", trg_cnt - t0, sts_run);
    end
  endtask

  task automatic test_clamp_live;
    cfg_num = 2'd3; cfg_rep = 16'd1;
    start;
    burst(0, 0, 1'b0, 1'b1);
    for (int e = 1; e < 4; e++) burst(e, 0, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) burst(e, 1, 1'b0, 1'b0);
    vectors++;
    if (irq_don !== 1'b1 || sts_idx !== 2'd3 || sts_rep !== 16'd1) begin
      errs++; $display("FAIL clamp_done: don=%b idx=%0d rep=%0d required 1 3 1", irq_don, sts_idx, sts_rep);
    end
    tick;
  endtask

  task automatic test_inf_abort;
    int d0, a0;
    cfg_num = 2'd2; cfg_rep = 16'd0; cfg_inf = 1'b1;
    d0 = don_cnt; a0 = abt_cnt;
    start;
    for (int k = 0; k < 9; k++) burst(k % 3, k / 3, 1'b0, 1'b0);
    vectors++;
    if (asg_rst !== 1'b1 || sts_idx !== 2'd0 || sts_rep !== 16'd3) begin
      errs++; $display("FAIL inf_wrap: rst=%b idx=%0d rep=%0d required 1 0 3", asg_rst, sts_idx, sts_rep);
    end
    repeat (5) tick;
    asg_stp = 1'b1; ctl_stp = 1'b1;
    tick;
    asg_stp = 1'b0; ctl_stp = 1'b0;
    vectors++;
    if (asg_rst !== 1'b1 || irq_abt !== 1'b1 || irq_don !== 1'b0 || sts_run !== 1'b1) begin
      errs++; $display("FAIL abort_pulse: rst/abt/don/run=%b%b%b%b required 1101", asg_rst, irq_abt, irq_don, sts_run);
    end
    tick;
    vectors++;
    if (sts_run !== 1'b0 || irq_abt !== 1'b0 || asg_rst !== 1'b0 || don_cnt != d0 || abt_cnt - a0 != 1) begin
      errs++; $display("FAIL abort_idle: run/abt/rst=%b%b%b don_pulses=%0d abt_pulses=%0d required 000 0 1",
                       sts_run, irq_abt, asg_rst, don_cnt - d0, abt_cnt - a0);
    end
    cfg_inf = 1'b0;
  endtask

  task automatic test_reset_mid;
    cfg_num = 2'd2; cfg_rep = 16'd0;
    start;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if ({asg_rst, asg_trg, irq_don, irq_abt, sts_run} !== 5'b0 || sts_idx !== 2'd0 || sts_rep !== 16'd0 ||
        {asg_bdl, asg_bln, asg_bnm} !== 62'd0) begin
      errs++; $display("FAIL reset_mid: ctl=%b idx=%0d rep=%0d cfg=%h required all zero",
                       {asg_rst, asg_trg, irq_don, irq_abt, sts_run}, sts_idx, sts_rep, {asg_bdl, asg_bln, asg_bnm});
    end
    for (int i = 0; i < 4; i++) begin m_bdl[i] = '0; m_bln[i] = '0; m_bnm[i] = '0; end
    cfg_num = 2'd0;
    start;
    burst(0, 0, 1'b0, 1'b0);
    vectors++;
    if (irq_don !== 1'b1) begin
      errs++; $display("FAIL reset_tbl_done: don=%b required 1", irq_don);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_idle_events;
    test_basic;
    test_repeat;
    test_clamp_live;
    test_inf_abort;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
